// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage : MEM pipeline stage, direct-mapped write-through cache,
//                    RAM req/ack FSM. Optional counters: MEM_STAGE_STATS_EN.
// Revision 1.0
// ============================================================================
module mem_access_stage #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16,
  parameter int WB_W       = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         iValid,
  input  logic [WB_W-1:0]              iSIGS_WB,
  input  logic                         iSig_MemRead,
  input  logic                         iSig_MemWrite,
  input  logic                         iSig_branch,
  input  logic                         iALUzero,
  input  logic [31:0]                  iALUresult,
  input  logic [DATA_W-1:0]            iregfile_read_data2,
  output logic                         oStall,
  output logic                         oValid,
  output logic [DATA_W-1:0]            oMemReadData,
  output logic [31:0]                  oALUresult,
  output logic [WB_W-1:0]              oSIGS_WB,
  output logic                         oSig_PCSrc,
  output logic                         oram_req,
  output logic                         oram_we,
  output logic [31:0]                  oram_addr,
  output logic [DATA_W-1:0]            oram_wdata,
  input  logic                         iram_ack,
  input  logic [DATA_W*LINE_WORDS-1:0] iram_rdata
`ifdef MEM_STAGE_STATS_EN
  ,
  output logic [31:0]                  oHitCount,
  output logic [31:0]                  oMissCount
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [NUM_LINES-1:0]           valid_q;
  logic [TAG_W-1:0]               tag_q  [NUM_LINES];
  logic [DATA_W*LINE_WORDS-1:0]   line_q [NUM_LINES];

  logic                           req_q, req_d, we_q, we_d;
  logic [31:0]                    addr_q, addr_d;
  logic [DATA_W-1:0]              wdata_q, wdata_d;
  logic                           valid_out_q;
  logic [DATA_W-1:0]              rdata_q;
  logic [31:0]                    alu_q;
  logic [WB_W-1:0]                wb_q;

  logic [OFF_W-1:0]               off;
  logic [IDX_W-1:0]               idx;
  logic [TAG_W-1:0]               tag;
  logic                           hit, rd, wr, stall;
  logic [DATA_W-1:0]              cache_word;

  assign off        = iALUresult[OFF_W+1:2];
  assign idx        = iALUresult[OFF_W+2 +: IDX_W];
  assign tag        = iALUresult[31 -: TAG_W];
  assign hit        = valid_q[idx] & (tag_q[idx] == tag);
  // A simultaneous read+write is handled purely as a write.
  assign wr         = iValid & iSig_MemWrite;
  assign rd         = iValid & iSig_MemRead & ~iSig_MemWrite;
  assign cache_word = line_q[idx][off*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (wr) begin
          stall   = 1'b1;
          state_d = S_WRITE;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = {iALUresult[31:2], 2'b00};
          wdata_d = iregfile_read_data2;
        end else if (rd && !hit) begin
          stall   = 1'b1;
          state_d = S_FILL;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {iALUresult[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        end
      end
      S_FILL: begin
        stall = 1'b1;
        if (iram_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      S_WRITE: begin
        if (iram_ack) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      valid_out_q <= 1'b0;
      rdata_q     <= '0;
      alu_q       <= '0;
      wb_q        <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == S_FILL && iram_ack) valid_q[idx] <= 1'b1;
      if (!stall) begin
        valid_out_q <= iValid;
        alu_q       <= iALUresult;
        wb_q        <= iSIGS_WB;
        rdata_q     <= rd ? cache_word : '0;
      end else begin
        valid_out_q <= 1'b0;
      end
    end
  end

  // Tag/data arrays are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && wr && hit) line_q[idx][off*DATA_W +: DATA_W] <= iregfile_read_data2;
    if (state_q == S_FILL && iram_ack) begin
      line_q[idx] <= iram_rdata;
      tag_q[idx]  <= tag;
    end
  end

`ifdef MEM_STAGE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        filled_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      filled_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && state_d == S_FILL && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      // A read retiring straight after its own fill is a miss, not a hit.
      if (state_q == S_FILL && iram_ack) begin
        filled_q <= 1'b1;
      end else if (rd && !stall) begin
        filled_q <= 1'b0;
        if (!filled_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
    end
  end

  assign oHitCount  = hit_cnt_q;
  assign oMissCount = miss_cnt_q;
`endif

  assign oStall       = stall;
  assign oValid       = valid_out_q;
  assign oMemReadData = rdata_q;
  assign oALUresult   = alu_q;
  assign oSIGS_WB     = wb_q;
  assign oSig_PCSrc   = iValid & iSig_branch & iALUzero;
  assign oram_req     = req_q;
  assign oram_we      = we_q;
  assign oram_addr    = addr_q;
  assign oram_wdata   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_access_stage : scoreboard bench for mem_access_stage with a RAM model.
// Revision 1.0
// ============================================================================
module tb_mem_access_stage;
  localparam int DW = 32, LW = 4, NL = 16, WBW = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic            iValid, iSig_MemRead, iSig_MemWrite, iSig_branch, iALUzero;
  logic [WBW-1:0]  iSIGS_WB;
  logic [31:0]     iALUresult;
  logic [DW-1:0]   iregfile_read_data2;
  logic            oStall, oValid, oSig_PCSrc, oram_req, oram_we;
  logic [DW-1:0]   oMemReadData, oram_wdata;
  logic [31:0]     oALUresult, oram_addr;
  logic [WBW-1:0]  oSIGS_WB;
  logic            iram_ack;
  logic [DW*LW-1:0] iram_rdata;
`ifdef MEM_STAGE_STATS_EN
  logic [31:0]     oHitCount, oMissCount;
`endif

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .LINE_WORDS(LW), .NUM_LINES(NL), .WB_W(WBW)) dut (
    .clk(clk), .rstn(rstn), .iValid(iValid), .iSIGS_WB(iSIGS_WB),
    .iSig_MemRead(iSig_MemRead), .iSig_MemWrite(iSig_MemWrite),
    .iSig_branch(iSig_branch), .iALUzero(iALUzero), .iALUresult(iALUresult),
    .iregfile_read_data2(iregfile_read_data2), .oStall(oStall), .oValid(oValid),
    .oMemReadData(oMemReadData), .oALUresult(oALUresult), .oSIGS_WB(oSIGS_WB),
    .oSig_PCSrc(oSig_PCSrc), .oram_req(oram_req), .oram_we(oram_we),
    .oram_addr(oram_addr), .oram_wdata(oram_wdata), .iram_ack(iram_ack),
    .iram_rdata(iram_rdata)
`ifdef MEM_STAGE_STATS_EN
    , .oHitCount(oHitCount), .oMissCount(oMissCount)
`endif
  );

  int checks = 0, failures = 0;
  int exp_hit = 0, exp_miss = 0;
  logic [WBW-1:0] wb_ctr = '0;

  typedef struct packed {
    logic [31:0]    data;
    logic [31:0]    alu;
    logic [WBW-1:0] wb;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ram [int];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rstn && oValid) begin
      if (sb.size() == 0) begin
        check_val("unexpected_retire", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("rdata", oMemReadData, e.data);
        check_val("alu", oALUresult, e.alu);
        check_val("wb", oSIGS_WB, e.wb);
      end
    end
  end

  // op: 0 = no memory access, 1 = read, 2 = write. n = cycles from req to ack.
  task automatic do_access(input int op, input logic [31:0] addr, input logic [31:0] wd,
                           input int n, input bit exp_req);
    int   cyc = 0, req_cyc = -1, stalls = 0;
    bit   done = 0, acked = 0;
    exp_t e;
    logic [31:0] base, waddr;
    waddr = {addr[31:2], 2'b00};
    base  = {addr[31:4], 4'h0};
    iValid = 1'b1; iSig_MemRead = (op == 1); iSig_MemWrite = (op == 2);
    iALUresult = addr; iregfile_read_data2 = wd; iSIGS_WB = wb_ctr;
    e.alu = addr; e.wb = wb_ctr;
    e.data = (op == 1) ? ram_word(waddr) : 32'h0;
    if (op == 2) ram[waddr] = wd;
    if (op == 1 && exp_req) exp_miss++;
    else if (op == 1) exp_hit++;
    wb_ctr++;
    sb.push_back(e);
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (oram_req && req_cyc < 0) begin
        req_cyc = cyc;
        check_val("ram_we", oram_we, (op == 2));
        check_val("ram_addr", oram_addr, (op == 2) ? waddr : base);
        if (op == 2) check_val("ram_wdata", oram_wdata, wd);
      end
      if (req_cyc >= 0 && !acked && cyc == req_cyc + n) begin
        iram_ack = 1'b1;
        for (int w = 0; w < LW; w++) iram_rdata[w*DW +: DW] = ram_word(base + 32'(4*w));
        acked = 1;
      end
      #1;
      if (oStall) stalls++;
      else done = 1;
      @(posedge clk); #1;
      iram_ack = 1'b0;
      cyc++;
    end
    check_val("retired", done, 1);
    check_val("req_issued", (req_cyc >= 0), exp_req);
    check_val("stall_cycles", stalls, (op == 1 && exp_req) ? n + 2 : (op == 2) ? n + 1 : 0);
  endtask

  initial begin
    rstn = 1'b0; iValid = 0; iSig_MemRead = 0; iSig_MemWrite = 0; iSig_branch = 0;
    iALUzero = 0; iSIGS_WB = '0; iALUresult = '0; iregfile_read_data2 = '0;
    iram_ack = 0; iram_rdata = '0;
    ram[32'h40] = 32'hA; ram[32'h44] = 32'hB; ram[32'h48] = 32'hC; ram[32'h4C] = 32'hD;
    repeat (2) @(posedge clk); #1;
    check_val("rst_oValid", oValid, 0);
    check_val("rst_rdata", oMemReadData, 0);
    check_val("rst_alu", oALUresult, 0);
    check_val("rst_wb", oSIGS_WB, 0);
    check_val("rst_req", oram_req, 0);
    check_val("rst_we", oram_we, 0);
    check_val("rst_addr", oram_addr, 0);
    check_val("rst_wdata", oram_wdata, 0);
    check_val("rst_stall", oStall, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    do_access(1, 32'h40, 0, 3, 1);            // cold miss, fill {D,C,B,A}
    do_access(1, 32'h44, 0, 0, 0);            // hit in freshly filled line
    do_access(2, 32'h48, 32'h1234, 2, 1);     // write hit, write-through
    do_access(1, 32'h48, 0, 0, 0);
    do_access(2, 32'h100, 32'h55, 1, 1);      // write miss, no allocate
    do_access(1, 32'h100, 0, 2, 1);
    do_access(1, 32'h104, 0, 0, 0);
    do_access(1, 32'h140, 0, 1, 1);           // evicts 0x40 (same index)
    do_access(1, 32'h40, 0, 4, 1);

    iSig_branch = 1; iALUzero = 1; iValid = 1; #1;
    check_val("pcsrc_taken", oSig_PCSrc, 1);
    iValid = 0; #1;
    check_val("pcsrc_invalid", oSig_PCSrc, 0);
    do_access(0, 32'h77, 0, 0, 0);
    iSig_branch = 0; iALUzero = 0;
    iValid = 0; iSig_MemRead = 0; iSig_MemWrite = 0;
    repeat (3) @(posedge clk); #1;
    check_val("sb_drained", sb.size(), 0);
`ifdef MEM_STAGE_STATS_EN
    check_val("hit_count", oHitCount, exp_hit);
    check_val("miss_count", oMissCount, exp_miss);
`endif

    // Reset while a fill is outstanding.
    iValid = 1; iSig_MemRead = 1; iALUresult = 32'h80;
    for (int k = 0; k < 20 && !oram_req; k++) @(negedge clk);
    check_val("fill_req", oram_req, 1);
    #1 rstn = 1'b0;
    #1;
    check_val("rst_fill_req", oram_req, 0);
    check_val("rst_fill_valid", oValid, 0);
    iValid = 0; iSig_MemRead = 0;
    exp_hit = 0; exp_miss = 0;
    @(posedge clk); #1 iram_ack = 1'b1;
    @(posedge clk); #1 iram_ack = 1'b0;
    rstn = 1'b1;
    @(negedge clk) iram_ack = 1'b1;
    @(posedge clk); #1 iram_ack = 1'b0;
    @(negedge clk);
    check_val("late_ack_req", oram_req, 0);
    check_val("late_ack_stall", oStall, 0);
    @(posedge clk); #1;
    do_access(1, 32'h40, 0, 2, 1);
    iValid = 0; iSig_MemRead = 0;
    repeat (3) @(posedge clk); #1;
    check_val("sb_drained_end", sb.size(), 0);
`ifdef MEM_STAGE_STATS_EN
    check_val("hit_count_end", oHitCount, exp_hit);
    check_val("miss_count_end", oMissCount, exp_miss);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
